// File: rtl/wb_serial_master.sv
// wb_serial_master
// Wishbone classic-cycle master that takes commands from a UART byte stream and
// returns the response as bytes, so a host can read and write the SoC address space.
//   Command : 0x01 (write) or 0x02 (read), then 4 address bytes MSB first.
//             A write is followed by 4 data bytes, MSB first.
//   Response: 0x06 after a write, 4 data bytes MSB first after a read,
//             or 0x15 on bus error or bus timeout.
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   rx_data, rx_avail   received byte and its one-cycle strobe
//   tx_data, tx_wr      byte to send and its one-cycle strobe
//   tx_busy             transmitter busy
//   wb_*                Wishbone master port, single classic cycles only
//   busy                high whenever the FSM is not idle
// Parameters
//   wb_timeout          stb cycles allowed before the bus cycle is aborted (>= 2)
//   rx_timeout          idle cycles allowed between bytes of one command (>= 2)
module wb_serial_master #(
    parameter int unsigned wb_timeout = 1024,
    parameter int unsigned rx_timeout = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy
);

    localparam int unsigned WB_W = $clog2(wb_timeout);
    localparam int unsigned RX_W = $clog2(rx_timeout);
    localparam logic [WB_W-1:0] WB_LAST = WB_W'(wb_timeout - 1);
    localparam logic [RX_W-1:0] RX_LAST = RX_W'(rx_timeout - 1);

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;
    localparam logic [7:0] RSP_OK = 8'h06;
    localparam logic [7:0] RSP_NG = 8'h15;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

    state_t          state, state_next;
    logic [1:0]      cnt;
    logic [31:0]     adr, dat;
    logic            we, err;
    logic            cyc;
    logic [RX_W-1:0] rx_cnt;
    logic [WB_W-1:0] wb_cnt;
    logic            tx_gap;

    logic            cmd_ok, last_byte, rx_expire, wb_term;
    logic [1:0]      resp_last;
    logic            tx_ready, tx_done;

    assign cmd_ok    = rx_avail && (rx_data == CMD_WR || rx_data == CMD_RD);
    assign last_byte = rx_avail && (cnt == 2'd3);
    assign rx_expire = !rx_avail && (rx_cnt == RX_LAST);
    // The timeout counter holds k during the (k+1)-th stb cycle, so the last
    // allowed stb cycle is the one where it equals wb_timeout-1.
    assign wb_term   = wb_ack_i || wb_err_i || (wb_cnt == WB_LAST);
    assign resp_last = (we || err) ? 2'd0 : 2'd3;
    // tx_busy is not looked at in the tx_wr cycle nor in the cycle after it,
    // giving the transmitter time to raise busy.
    assign tx_ready  = (state == RESP) && !tx_wr && !tx_gap && !tx_busy;
    assign tx_done   = tx_wr && (cnt == resp_last);

    assign wb_adr_o = adr;
    assign wb_dat_o = dat;
    assign wb_cyc_o = cyc;
    assign wb_stb_o = cyc;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (cmd_ok) state_next = ADDR;
            ADDR: begin
                if (last_byte)      state_next = we ? DATA : BUS;
                else if (rx_expire) state_next = IDLE;
            end
            DATA: begin
                if (last_byte)      state_next = BUS;
                else if (rx_expire) state_next = IDLE;
            end
            BUS:  if (wb_term) state_next = RESP;
            RESP: if (tx_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            adr      <= '0;
            dat      <= '0;
            we       <= 1'b0;
            err      <= 1'b0;
            cyc      <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            rx_cnt   <= '0;
            wb_cnt   <= '0;
            tx_wr    <= 1'b0;
            tx_data  <= '0;
            tx_gap   <= 1'b0;
        end else begin
            tx_wr  <= 1'b0;
            tx_gap <= tx_wr;
            case (state)
                IDLE: begin
                    cnt    <= '0;
                    rx_cnt <= '0;
                    if (cmd_ok) we <= (rx_data == CMD_WR);
                end
                ADDR, DATA: begin
                    if (rx_avail) begin
                        rx_cnt <= '0;
                        cnt    <= cnt + 2'd1;
                        if (state == ADDR) adr <= {adr[23:0], rx_data};
                        else               dat <= {dat[23:0], rx_data};
                        if (cnt == 2'd3 && (state == DATA || !we)) begin
                            cyc      <= 1'b1;
                            wb_we_o  <= we;
                            wb_sel_o <= 4'hF;
                            wb_cnt   <= '0;
                        end
                    end else if (rx_expire) begin
                        rx_cnt <= '0;
                        cnt    <= '0;
                    end else begin
                        rx_cnt <= rx_cnt + RX_W'(1);
                    end
                end
                BUS: begin
                    if (wb_term) begin
                        cyc      <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= '0;
                        // err has priority over ack; a timeout is neither.
                        err      <= wb_err_i || !wb_ack_i;
                        if (wb_ack_i && !wb_err_i && !we) dat <= wb_dat_i;
                    end else begin
                        wb_cnt <= wb_cnt + WB_W'(1);
                    end
                end
                RESP: begin
                    if (tx_ready) begin
                        tx_wr <= 1'b1;
                        if (err)     tx_data <= RSP_NG;
                        else if (we) tx_data <= RSP_OK;
                        else         tx_data <= dat[31:24];
                    end else if (tx_wr) begin
                        dat <= {dat[23:0], 8'h00};
                        cnt <= tx_done ? 2'd0 : cnt + 2'd1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule
